// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Shares the single register-file write port between N_REQ write-back
// requesters (ALU, LSU, MUL/DIV). The requesters are served in round-robin
// order, and the chosen write goes through one register stage before it
// reaches the register file. A pending-write scoreboard holds one bit per
// register. Issue logic sets a bit, and a committed write clears it. The
// decoder uses sb_pending to stall on hazards.
//
// Optional feature (compile-time macro REGFILE_WB_X0_DROP_EN):
//   defined   - register 0 is hard-wired. A request to address 0 still
//               completes its handshake and still advances the pointer, but
//               it never asserts rf_write_en. A scoreboard set of register 0
//               is ignored.
//   undefined - register 0 behaves like any other register.
//
// Parameters:
//   WIDTH  data width of one register
//   N      number of registers (address width is $clog2(N))
//   N_REQ  number of write-back requesters (>= 2)
//
// Ports:
//   clk            clock; all state updates on posedge
//   rst            asynchronous active-high reset
//   req_valid      [N_REQ]        requester i holds a write
//   req_ready      [N_REQ]        requester i accepted this cycle (combinational)
//   req_addr       [N_REQ][AW]    destination register per requester
//   req_data       [N_REQ][WIDTH] write data per requester
//   sb_set_valid                  issue logic marks a register pending
//   sb_set_addr    [AW]           register to mark
//   sb_pending     [N]            bit r set while a write to r is outstanding
//   rf_write_en                   register file write enable (registered)
//   rf_write_addr  [AW]           register file write address (registered)
//   rf_data_in     [WIDTH]        register file write data (registered)
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int WIDTH = 32,
  parameter int N     = 32,
  parameter int N_REQ = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N_REQ-1:0]                   req_valid,
  output logic [N_REQ-1:0]                   req_ready,
  input  logic [N_REQ-1:0][$clog2(N)-1:0]    req_addr,
  input  logic [N_REQ-1:0][WIDTH-1:0]        req_data,
  input  logic                               sb_set_valid,
  input  logic [$clog2(N)-1:0]               sb_set_addr,
  output logic [N-1:0]                       sb_pending,
  output logic                               rf_write_en,
  output logic [$clog2(N)-1:0]               rf_write_addr,
  output logic [WIDTH-1:0]                   rf_data_in
);

  localparam int AW = $clog2(N);
  localparam int PW = $clog2(N_REQ);

  // State
  logic [PW-1:0]    r_rr_ptr;
  logic             r_write_en;
  logic [AW-1:0]    r_write_addr;
  logic [WIDTH-1:0] r_data;
  logic [N-1:0]     r_pending;

  // Combinational arbitration results
  logic [N_REQ-1:0] w_grant;
  logic             w_any_grant;
  logic [AW-1:0]    w_sel_addr;
  logic [WIDTH-1:0] w_sel_data;
  logic [PW-1:0]    w_next_ptr;
  logic             w_commit;
  logic             w_set_ok;
  logic [N-1:0]     w_pending_next;

  // Round-robin scan. Starting at r_rr_ptr, take the first valid requester.
  // The inner loop compares each index against the rotated position. This
  // keeps every array select at a constant index.
  // NOTE: every signal that an always_comb block writes gets a default first.
  // Without the default, a path that skips the assignment would infer a latch.
  always_comb begin
    int   pos;
    logic found;
    w_grant = '0;
    found   = 1'b0;
    pos     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = int'(r_rr_ptr) + k;
      if (pos >= N_REQ) pos = pos - N_REQ;
      for (int i = 0; i < N_REQ; i++) begin
        if (!found && (i == pos) && req_valid[i]) begin
          w_grant[i] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

  // Mux out the granted request and compute the pointer that follows it.
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    w_next_ptr = r_rr_ptr;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_addr = req_addr[i];
        w_sel_data = req_data[i];
        w_next_ptr = (i == N_REQ - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  assign w_any_grant = |w_grant;
  assign req_ready   = rst ? '0 : w_grant;

`ifdef REGFILE_WB_X0_DROP_EN
  // A write to register 0 is accepted but never reaches the register file.
  assign w_commit = w_any_grant && (w_sel_addr != '0);
  assign w_set_ok = sb_set_valid && (sb_set_addr != '0);
`else
  assign w_commit = w_any_grant;
  assign w_set_ok = sb_set_valid;
`endif

  // Scoreboard update. The clear is applied first and the set second, so a
  // new producer issued to the register being retired keeps its bit set.
  always_comb begin
    w_pending_next = r_pending;
    if (r_write_en) w_pending_next[r_write_addr] = 1'b0;
    if (w_set_ok)   w_pending_next[sb_set_addr]  = 1'b1;
  end

  // NOTE: sequential state is assigned with non-blocking (<=) assignments.
  // All flops then update together on the edge, and no block sees another
  // block's new value in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr     <= '0;
      r_write_en   <= 1'b0;
      r_write_addr <= '0;
      r_data       <= '0;
      // NOTE: the scoreboard is an N-bit flop vector and not a RAM. The
      // decoder reads it every cycle, so it must be reset explicitly to
      // avoid stalling on stale bits.
      r_pending    <= '0;
    end else begin
      r_pending  <= w_pending_next;
      r_write_en <= w_commit;
      if (w_any_grant) r_rr_ptr <= w_next_ptr;
      if (w_commit) begin
        r_write_addr <= w_sel_addr;
        r_data       <= w_sel_data;
      end
    end
  end

  assign rf_write_en   = r_write_en;
  assign rf_write_addr = r_write_addr;
  assign rf_data_in    = r_data;
  assign sb_pending    = r_pending;

  // At most one requester is accepted per cycle.
  a_onehot_ready: assert property (@(posedge clk) disable iff (rst)
    $onehot0(req_ready));

  // Addresses at or above N exist only when N is not a power of two.
  generate
    if ((1 << AW) != N) begin : g_addr_chk
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
        a_req_addr: assert property (@(posedge clk) disable iff (rst)
          req_valid[gi] |-> (int'(req_addr[gi]) < N));
      end
      a_set_addr: assert property (@(posedge clk) disable iff (rst)
        sb_set_valid |-> (int'(sb_set_addr) < N));
    end
  endgenerate

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int WIDTH = 32;
  localparam int N     = 32;
  localparam int N_REQ = 3;
  localparam int AW    = 5;

  logic                          clk;
  logic                          rst;
  logic [N_REQ-1:0]              req_valid;
  logic [N_REQ-1:0]              req_ready;
  logic [N_REQ-1:0][AW-1:0]      req_addr;
  logic [N_REQ-1:0][WIDTH-1:0]   req_data;
  logic                          sb_set_valid;
  logic [AW-1:0]                 sb_set_addr;
  logic [N-1:0]                  sb_pending;
  logic                          rf_write_en;
  logic [AW-1:0]                 rf_write_addr;
  logic [WIDTH-1:0]              rf_data_in;

  regfile_wb_arbiter #(.WIDTH(WIDTH), .N(N), .N_REQ(N_REQ)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .sb_set_valid  (sb_set_valid),
    .sb_set_addr   (sb_set_addr),
    .sb_pending    (sb_pending),
    .rf_write_en   (rf_write_en),
    .rf_write_addr (rf_write_addr),
    .rf_data_in    (rf_data_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record is one cycle. The inputs are driven at negedge, exp_ready is
  // compared in the same cycle, and the registered outputs are compared just
  // after the following posedge.
  typedef struct {
    logic        rst;
    logic [2:0]  valid;
    logic [4:0]  a0, a1, a2;
    logic [31:0] d0, d1, d2;
    logic        set_v;
    logic [4:0]  set_a;
    logic [2:0]  exp_ready;
    logic        exp_en;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic [31:0] exp_pend;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic r, input logic [2:0] v,
    input logic [4:0] a0, input logic [31:0] d0,
    input logic [4:0] a1, input logic [31:0] d1,
    input logic [4:0] a2, input logic [31:0] d2,
    input logic sv, input logic [4:0] sa,
    input logic [2:0] er, input logic ee, input logic [4:0] ea,
    input logic [31:0] ed, input logic [31:0] ep);
    vec_t x;
    x.rst = r; x.valid = v;
    x.a0 = a0; x.a1 = a1; x.a2 = a2;
    x.d0 = d0; x.d1 = d1; x.d2 = d2;
    x.set_v = sv; x.set_a = sa;
    x.exp_ready = er; x.exp_en = ee; x.exp_addr = ea;
    x.exp_data = ed; x.exp_pend = ep;
    return x;
  endfunction

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    rst          = v.rst;
    req_valid    = v.valid;
    req_addr[0]  = v.a0; req_addr[1] = v.a1; req_addr[2] = v.a2;
    req_data[0]  = v.d0; req_data[1] = v.d1; req_data[2] = v.d2;
    sb_set_valid = v.set_v;
    sb_set_addr  = v.set_a;
    #1;
    check($sformatf("v%0d.ready", idx), 32'(req_ready), 32'(v.exp_ready));
    @(posedge clk);
    #1;
    check($sformatf("v%0d.en", idx),   32'(rf_write_en),   32'(v.exp_en));
    check($sformatf("v%0d.addr", idx), 32'(rf_write_addr), 32'(v.exp_addr));
    check($sformatf("v%0d.data", idx), rf_data_in,         v.exp_data);
    check($sformatf("v%0d.pend", idx), sb_pending,         v.exp_pend);
  endtask

  task automatic run_table(input int base);
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], base + i);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
    sb_set_valid = 1'b0; sb_set_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.en",    32'(rf_write_en), 32'h0);
    check("rst.pend",  sb_pending,       32'h0);
    check("rst.ready", 32'(req_ready),   32'h0);

    // ----- phase 1 table
    //                r  v      a0  d0            a1 d1            a2 d2     sv sa   er    ee a   data          pend
    // Idle after reset
    vecs.push_back(mk(0, 3'b000, 0, 0,            0, 0,            0, 0,     0, 0,   3'b000, 0, 0,  0,            0));
    vecs.push_back(mk(0, 3'b000, 0, 0,            0, 0,            0, 0,     0, 0,   3'b000, 0, 0,  0,            0));
    vecs.push_back(mk(0, 3'b000, 0, 0,            0, 0,            0, 0,     0, 0,   3'b000, 0, 0,  0,            0));
    // Single write from requester 1; the address and data hold afterwards
    vecs.push_back(mk(0, 3'b010, 0, 0,            5, 32'hDEADBEEF, 0, 0,     0, 0,   3'b010, 1, 5,  32'hDEADBEEF, 0));
    vecs.push_back(mk(0, 3'b000, 0, 0,            0, 0,            0, 0,     0, 0,   3'b000, 0, 5,  32'hDEADBEEF, 0));
    // Scoreboard: set 7, hold, then a write to 7 clears it one cycle after commit
    vecs.push_back(mk(0, 3'b000, 0, 0,            0, 0,            0, 0,     1, 7,   3'b000, 0, 5,  32'hDEADBEEF, 32'h80));
    vecs.push_back(mk(0, 3'b000, 0, 0,            0, 0,            0, 0,     0, 0,   3'b000, 0, 5,  32'hDEADBEEF, 32'h80));
    vecs.push_back(mk(0, 3'b001, 7, 32'h77,       0, 0,            0, 0,     0, 0,   3'b001, 1, 7,  32'h77,       32'h80)); // ptr=2 wraps to 0
    vecs.push_back(mk(0, 3'b000, 0, 0,            0, 0,            0, 0,     0, 0,   3'b000, 0, 7,  32'h77,       0));
    // Set/clear collision on register 9: the set wins
    vecs.push_back(mk(0, 3'b100, 0, 0,            0, 0,            9, 32'h99,0, 0,   3'b100, 1, 9,  32'h99,       0));
    vecs.push_back(mk(0, 3'b000, 0, 0,            0, 0,            0, 0,     1, 9,   3'b000, 0, 9,  32'h99,       32'h200));
    // Set and clear on different registers, then a clear of an already-clear bit
    vecs.push_back(mk(0, 3'b010, 0, 0,            3, 32'h33,       0, 0,     1, 3,   3'b010, 1, 3,  32'h33,       32'h208));
    vecs.push_back(mk(0, 3'b000, 0, 0,            0, 0,            0, 0,     1, 10,  3'b000, 0, 3,  32'h33,       32'h600));
    vecs.push_back(mk(0, 3'b100, 0, 0,            0, 0,            3, 32'h3A,0, 0,   3'b100, 1, 3,  32'h3A,       32'h600));
    vecs.push_back(mk(0, 3'b000, 0, 0,            0, 0,            0, 0,     0, 0,   3'b000, 0, 3,  32'h3A,       32'h600));
    // Top register 31 with all-ones data
    vecs.push_back(mk(0, 3'b001, 31, 32'hFFFFFFFF,0, 0,            0, 0,     1, 31,  3'b001, 1, 31, 32'hFFFFFFFF, 32'h80000600));
    vecs.push_back(mk(0, 3'b000, 0, 0,            0, 0,            0, 0,     0, 0,   3'b000, 0, 31, 32'hFFFFFFFF, 32'h600));
    // Synchronous-style reset record, then round-robin with all requesters valid
    vecs.push_back(mk(1, 3'b111, 1, 32'hA0,       2, 32'hB1,       3, 32'hC2,0, 0,   3'b000, 0, 0,  0,            0));
    vecs.push_back(mk(0, 3'b111, 1, 32'hA0,       2, 32'hB1,       3, 32'hC2,0, 0,   3'b001, 1, 1,  32'hA0,       0));
    vecs.push_back(mk(0, 3'b111, 1, 32'hA0,       2, 32'hB1,       3, 32'hC2,0, 0,   3'b010, 1, 2,  32'hB1,       0));
    vecs.push_back(mk(0, 3'b111, 1, 32'hA0,       2, 32'hB1,       3, 32'hC2,0, 0,   3'b100, 1, 3,  32'hC2,       0));
    vecs.push_back(mk(0, 3'b111, 1, 32'hA0,       2, 32'hB1,       3, 32'hC2,0, 0,   3'b001, 1, 1,  32'hA0,       0));
    vecs.push_back(mk(0, 3'b111, 1, 32'hA0,       2, 32'hB1,       3, 32'hC2,0, 0,   3'b010, 1, 2,  32'hB1,       0));
    vecs.push_back(mk(0, 3'b111, 1, 32'hA0,       2, 32'hB1,       3, 32'hC2,0, 0,   3'b100, 1, 3,  32'hC2,       0));
    vecs.push_back(mk(0, 3'b000, 0, 0,            0, 0,            0, 0,     0, 0,   3'b000, 0, 3,  32'hC2,       0));
    // Build pending = 0x0F00 and leave a write to 12 in the output stage (ptr ends at 2)
    vecs.push_back(mk(0, 3'b000, 0, 0,            0, 0,            0, 0,     1, 8,   3'b000, 0, 3,  32'hC2,       32'h100));
    vecs.push_back(mk(0, 3'b000, 0, 0,            0, 0,            0, 0,     1, 9,   3'b000, 0, 3,  32'hC2,       32'h300));
    vecs.push_back(mk(0, 3'b000, 0, 0,            0, 0,            0, 0,     1, 10,  3'b000, 0, 3,  32'hC2,       32'h700));
    vecs.push_back(mk(0, 3'b000, 0, 0,            0, 0,            0, 0,     1, 11,  3'b000, 0, 3,  32'hC2,       32'hF00));
    vecs.push_back(mk(0, 3'b010, 0, 0,            12, 32'h1234,    0, 0,     0, 0,   3'b010, 1, 12, 32'h1234,     32'hF00));
    run_table(0);

    // ----- asynchronous reset between edges with a write in flight
    #2;
    rst          = 1'b1;
    req_valid    = 3'b111;
    req_addr[0]  = 5'd1;  req_data[0] = 32'hA0;
    req_addr[1]  = 5'd2;  req_data[1] = 32'hB1;
    req_addr[2]  = 5'd3;  req_data[2] = 32'hC2;
    #1;
    check("arst.en",    32'(rf_write_en),   32'h0);
    check("arst.pend",  sb_pending,         32'h0);
    check("arst.addr",  32'(rf_write_addr), 32'h0);
    check("arst.data",  rf_data_in,         32'h0);
    check("arst.ready", 32'(req_ready),     32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst.first_grant", 32'(req_ready), 32'b001);
    @(posedge clk);
    #1;
    check("arst.after_en",   32'(rf_write_en),   32'h1);
    check("arst.after_addr", 32'(rf_write_addr), 32'h1);
    check("arst.after_data", rf_data_in,         32'hA0);

    // ----- phase 2: write and scoreboard set to register 0 (ptr=1, scan 1,2,0)
    vecs.delete();
`ifdef REGFILE_WB_X0_DROP_EN
    vecs.push_back(mk(0, 3'b001, 0, 32'h55, 0, 0, 0, 0, 1, 0, 3'b001, 0, 1, 32'hA0, 0));
    vecs.push_back(mk(0, 3'b000, 0, 0,      0, 0, 0, 0, 0, 0, 3'b000, 0, 1, 32'hA0, 0));
`else
    vecs.push_back(mk(0, 3'b001, 0, 32'h55, 0, 0, 0, 0, 1, 0, 3'b001, 1, 0, 32'h55, 1));
    vecs.push_back(mk(0, 3'b000, 0, 0,      0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 32'h55, 0));
`endif
    run_table(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
